// File: rtl/cache_perf_pkg.sv
// Shared types and constants for the cache performance monitor:
// FSM states, per-access latency classes and the AMAT fixed-point format.
package cache_perf_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, DIVIDE, DONE} state_t;

  typedef enum logic [1:0] {L1HIT, L2HIT, MEMACC} lat_class_t;

  localparam int Q_FRAC = 8;

  // An L1 hit masks whatever the L2 reports for the same access.
  function automatic lat_class_t classify(input logic l1, input logic l2);
    if (l1) return L1HIT;
    if (l2) return L2HIT;
    return MEMACC;
  endfunction

endpackage

// File: rtl/cache_perf_monitor_if.sv
// Control, access-stream and result-readout bundle of cache_perf_monitor.
// The master side drives the window and access stream; the monitor is the slave.
interface cache_perf_monitor_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 32,
  parameter int WIN_W  = 16
);
  localparam int RD_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              start;
  logic              abort;
  logic [WIN_W-1:0]  window_len;
  logic              acc_stb;
  logic [NUM_CH-1:0] l1_hit;
  logic [NUM_CH-1:0] l2_hit;
  logic              busy;
  logic              done;
  logic [RD_W-1:0]   rd_ch;
  logic [CNT_W-1:0]  rd_hit;
  logic [CNT_W-1:0]  rd_miss;
  logic [CNT_W-1:0]  rd_l2hit;
  logic [CNT_W+7:0]  rd_cycles;
  logic              rd_sat;
  logic [15:0]       rd_amat;

  modport master (
    output start, abort, window_len, acc_stb, l1_hit, l2_hit, rd_ch,
    input  busy, done, rd_hit, rd_miss, rd_l2hit, rd_cycles, rd_sat, rd_amat
  );

  modport slave (
    input  start, abort, window_len, acc_stb, l1_hit, l2_hit, rd_ch,
    output busy, done, rd_hit, rd_miss, rd_l2hit, rd_cycles, rd_sat, rd_amat
  );

endinterface

// File: rtl/perf_div_seq.sv
// Unsigned restoring divider, one quotient bit per cycle after a one-cycle load.
// done is high during the final iteration; quo then already holds the full quotient.
module perf_div_seq #(
  parameter int NUM_W = 56,
  parameter int DEN_W = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quo
);
  localparam int IT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] qr;
  logic [DEN_W-1:0] rem;
  logic [DEN_W-1:0] den_q;
  logic [IT_W-1:0]  iter;
  logic [DEN_W:0]   rem_sh;
  logic [DEN_W-1:0] rem_sub;
  logic             ge;

  // qr shifts the dividend out at the top while quotient bits enter at the bottom.
  always_comb begin
    rem_sh  = {rem, qr[NUM_W-1]};
    ge      = rem_sh >= {1'b0, den_q};
    rem_sub = rem_sh[DEN_W-1:0] - den_q;
    quo     = {qr[NUM_W-2:0], ge};
  end

  assign busy = (iter != '0);
  assign done = (iter == IT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qr    <= '0;
      rem   <= '0;
      den_q <= '0;
      iter  <= '0;
    end else if (start && !busy) begin
      qr    <= num;
      rem   <= '0;
      den_q <= den;
      iter  <= IT_W'(NUM_W);
    end else if (busy) begin
      qr    <= quo;
      rem   <= ge ? rem_sub : rem_sh[DEN_W-1:0];
      iter  <= iter - IT_W'(1);
    end
  end

endmodule

// File: rtl/cache_perf_monitor.sv
// Per-channel hit/miss/latency monitor over a window of accesses.
// Define CACHE_PERF_AMAT_EN to add the per-channel Q8.8 AMAT divide phase.
module cache_perf_monitor
  import cache_perf_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 32,
  parameter int WIN_W   = 16,
  parameter int L1_LAT  = 1,
  parameter int L2_LAT  = 5,
  parameter int MEM_LAT = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cache_perf_monitor_if.slave   bus
);
  localparam int RD_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CYC_W = CNT_W + 8;

  state_t            state, state_nxt;
  logic [WIN_W-1:0]  win_len, acc_cnt;
  logic [CNT_W-1:0]  hit_cnt [NUM_CH];
  logic [CNT_W-1:0]  miss_cnt[NUM_CH];
  logic [CNT_W-1:0]  l2h_cnt [NUM_CH];
  logic [CYC_W-1:0]  cyc_cnt [NUM_CH];
  logic [CNT_W-1:0]  hit_nxt [NUM_CH];
  logic [CNT_W-1:0]  miss_nxt[NUM_CH];
  logic [CNT_W-1:0]  l2h_nxt [NUM_CH];
  logic [CYC_W-1:0]  cyc_nxt [NUM_CH];
  logic [NUM_CH-1:0] sat_flag, sat_nxt;
  logic              strobe, win_end, clear;

  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] a);
    if (&a) return {1'b1, a};
    return {1'b0, a + CNT_W'(1)};
  endfunction

  function automatic logic [CYC_W:0] sat_add_cyc(input logic [CYC_W-1:0] a,
                                                 input logic [CYC_W-1:0] b);
    logic [CYC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[CYC_W]) return {1'b1, {CYC_W{1'b1}}};
    return s;
  endfunction

  function automatic logic [CYC_W-1:0] lat_of(input lat_class_t cls);
    case (cls)
      L1HIT:   return CYC_W'(L1_LAT);
      L2HIT:   return CYC_W'(L1_LAT + L2_LAT);
      default: return CYC_W'(L1_LAT + L2_LAT + MEM_LAT);
    endcase
  endfunction

  assign strobe  = (state == COUNT) && bus.acc_stb;
  assign win_end = strobe && (({1'b0, acc_cnt} + (WIN_W+1)'(1)) == {1'b0, win_len});
  assign clear   = (state == IDLE) && bus.start;

  always_comb begin : next_cnt
    lat_class_t     cls;
    logic [CNT_W:0] hit_r, miss_r, l2h_r;
    logic [CYC_W:0] cyc_r;
    for (int c = 0; c < NUM_CH; c++) begin
      cls         = classify(bus.l1_hit[c], bus.l2_hit[c]);
      hit_r       = sat_inc(hit_cnt[c]);
      miss_r      = sat_inc(miss_cnt[c]);
      l2h_r       = sat_inc(l2h_cnt[c]);
      cyc_r       = sat_add_cyc(cyc_cnt[c], lat_of(cls));
      hit_nxt[c]  = hit_cnt[c];
      miss_nxt[c] = miss_cnt[c];
      l2h_nxt[c]  = l2h_cnt[c];
      cyc_nxt[c]  = cyc_r[CYC_W-1:0];
      sat_nxt[c]  = sat_flag[c] | cyc_r[CYC_W];
      if (cls == L1HIT) begin
        hit_nxt[c] = hit_r[CNT_W-1:0];
        sat_nxt[c] = sat_nxt[c] | hit_r[CNT_W];
      end else begin
        miss_nxt[c] = miss_r[CNT_W-1:0];
        sat_nxt[c]  = sat_nxt[c] | miss_r[CNT_W];
        if (cls == L2HIT) begin
          l2h_nxt[c] = l2h_r[CNT_W-1:0];
          sat_nxt[c] = sat_nxt[c] | l2h_r[CNT_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_len  <= '0;
      acc_cnt  <= '0;
      sat_flag <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        hit_cnt[c]  <= '0;
        miss_cnt[c] <= '0;
        l2h_cnt[c]  <= '0;
        cyc_cnt[c]  <= '0;
      end
    end else if (clear) begin
      win_len  <= bus.window_len;
      acc_cnt  <= '0;
      sat_flag <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        hit_cnt[c]  <= '0;
        miss_cnt[c] <= '0;
        l2h_cnt[c]  <= '0;
        cyc_cnt[c]  <= '0;
      end
    end else if (strobe) begin
      acc_cnt  <= acc_cnt + WIN_W'(1);
      sat_flag <= sat_nxt;
      for (int c = 0; c < NUM_CH; c++) begin
        hit_cnt[c]  <= hit_nxt[c];
        miss_cnt[c] <= miss_nxt[c];
        l2h_cnt[c]  <= l2h_nxt[c];
        cyc_cnt[c]  <= cyc_nxt[c];
      end
    end
  end

`ifdef CACHE_PERF_AMAT_EN
  localparam int       NUM_W         = CNT_W + 24;
  localparam int       DEN_W         = CNT_W + 1;
  localparam state_t   WIN_END_STATE = DIVIDE;
  localparam [RD_W-1:0] LAST_CH      = RD_W'(NUM_CH - 1);

  logic [15:0]      amat [NUM_CH];
  logic [RD_W-1:0]  div_ch;
  logic             div_start, div_busy, div_done;
  logic [NUM_W-1:0] div_num, div_quo;
  logic [DEN_W-1:0] div_den;

  function automatic logic [15:0] sat_q88(input logic [NUM_W-1:0] q);
    return (|q[NUM_W-1:16]) ? 16'hFFFF : q[15:0];
  endfunction

  // Channels are divided one after another; an idle divider in DIVIDE means "load next".
  assign div_start = (state == DIVIDE) && !div_busy;
  assign div_num   = NUM_W'(cyc_cnt[div_ch]) << Q_FRAC;
  assign div_den   = DEN_W'(hit_cnt[div_ch]) + DEN_W'(miss_cnt[div_ch]);

  perf_div_seq #(.NUM_W(NUM_W), .DEN_W(DEN_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_ch <= '0;
      for (int c = 0; c < NUM_CH; c++) amat[c] <= '0;
    end else if (clear) begin
      div_ch <= '0;
      for (int c = 0; c < NUM_CH; c++) amat[c] <= '0;
    end else if (div_done) begin
      amat[div_ch] <= (div_den == '0) ? 16'h0000 : sat_q88(div_quo);
      if (div_ch != LAST_CH) div_ch <= div_ch + RD_W'(1);
    end
  end
`else
  localparam state_t WIN_END_STATE = DONE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = (state == COUNT) || (state == DIVIDE);
    bus.done  = (state == DONE);
    case (state)
      IDLE:   if (bus.start) state_nxt = (bus.window_len == '0) ? DONE : COUNT;
      COUNT: begin
        if (win_end)        state_nxt = WIN_END_STATE;
        else if (bus.abort) state_nxt = DONE;
      end
`ifdef CACHE_PERF_AMAT_EN
      DIVIDE: if (div_done && div_ch == LAST_CH) state_nxt = DONE;
`else
      DIVIDE: state_nxt = DONE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_hit    = '0;
    bus.rd_miss   = '0;
    bus.rd_l2hit  = '0;
    bus.rd_cycles = '0;
    bus.rd_sat    = 1'b0;
    bus.rd_amat   = '0;
    if (int'(bus.rd_ch) < NUM_CH) begin
      bus.rd_hit    = hit_cnt[bus.rd_ch];
      bus.rd_miss   = miss_cnt[bus.rd_ch];
      bus.rd_l2hit  = l2h_cnt[bus.rd_ch];
      bus.rd_cycles = cyc_cnt[bus.rd_ch];
      bus.rd_sat    = sat_flag[bus.rd_ch];
`ifdef CACHE_PERF_AMAT_EN
      bus.rd_amat   = amat[bus.rd_ch];
`endif
    end
  end

endmodule

// File: tb/tb_cache_perf_monitor.sv
// Directed bench for cache_perf_monitor: a default-width instance plus a
// 4-bit-counter instance for saturation. Build with CACHE_PERF_AMAT_EN to cover AMAT.
module tb_cache_perf_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CACHE_PERF_AMAT_EN
  localparam int EXP_DIV = 3 * (32 + 25);
`else
  localparam int EXP_DIV = 0;
`endif

  cache_perf_monitor_if #(.NUM_CH(3), .CNT_W(32), .WIN_W(16)) bus ();
  cache_perf_monitor_if #(.NUM_CH(3), .CNT_W(4),  .WIN_W(16)) sbus ();

  cache_perf_monitor #(.NUM_CH(3), .CNT_W(32), .WIN_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  cache_perf_monitor #(.NUM_CH(3), .CNT_W(4), .WIN_W(16)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.start  = 1'b0; bus.abort  = 1'b0; bus.window_len  = '0; bus.acc_stb  = 1'b0;
    bus.l1_hit = '0;   bus.l2_hit = '0;   bus.rd_ch       = '0;
    sbus.start = 1'b0; sbus.abort = 1'b0; sbus.window_len = '0; sbus.acc_stb = 1'b0;
    sbus.l1_hit = '0;  sbus.l2_hit = '0;  sbus.rd_ch      = '0;
  endtask

  task automatic start_window(input logic [15:0] len);
    bus.window_len = len;
    bus.start      = 1'b1;
    step();
    bus.start      = 1'b0;
  endtask

  task automatic strobe(input logic [2:0] l1, input logic [2:0] l2);
    bus.acc_stb = 1'b1;
    bus.l1_hit  = l1;
    bus.l2_hit  = l2;
    step();
    bus.acc_stb = 1'b0;
    bus.l1_hit  = '0;
    bus.l2_hit  = '0;
  endtask

  // Number of cycles until done rises, capped so a stuck FSM cannot hang the run.
  task automatic wait_done(output int k);
    k = 0;
    while (bus.done !== 1'b1 && k < 1000) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.start       = 1'($urandom);
    bus.abort       = 1'($urandom);
    bus.window_len  = 16'($urandom);
    bus.acc_stb     = 1'b1;
    bus.l1_hit      = 3'($urandom);
    bus.l2_hit      = 3'($urandom);
    sbus.acc_stb    = 1'b1;
    sbus.start      = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_busy_done: got %b, expected 00", {bus.busy, bus.done});
    end
    for (int ch = 0; ch < 4; ch++) begin
      bus.rd_ch = 2'(ch);
      #1;
      n_checks++;
      if ({bus.rd_hit, bus.rd_miss, bus.rd_l2hit, bus.rd_cycles, bus.rd_sat, bus.rd_amat} !== '0) begin
        n_fail++;
        $display("FAIL reset_rd_ch%0d: got hit=%0d miss=%0d l2=%0d cyc=%0d sat=%0d amat=%0h, expected all 0",
                 ch, bus.rd_hit, bus.rd_miss, bus.rd_l2hit, bus.rd_cycles, bus.rd_sat, bus.rd_amat);
      end
    end
    n_checks++;
    if ({sbus.busy, sbus.done, sbus.rd_hit, sbus.rd_sat} !== '0) begin
      n_fail++;
      $display("FAIL reset_small: got busy=%0d done=%0d hit=%0d sat=%0d, expected 0",
               sbus.busy, sbus.done, sbus.rd_hit, sbus.rd_sat);
    end
    drive_idle();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_count();
    logic [31:0] e_hit [3] = '{32'd4, 32'd0, 32'd0};
    logic [31:0] e_miss[3] = '{32'd0, 32'd4, 32'd4};
    logic [31:0] e_l2  [3] = '{32'd0, 32'd4, 32'd0};
    logic [39:0] e_cyc [3] = '{40'd4, 40'd24, 40'd424};
`ifdef CACHE_PERF_AMAT_EN
    logic [15:0] e_amat[3] = '{16'h0100, 16'h0600, 16'h6A00};
`else
    logic [15:0] e_amat[3] = '{16'h0, 16'h0, 16'h0};
`endif
    int k;
    int early;
    early = 0;
    start_window(16'd4);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL count_busy: got %0d, expected 1", bus.busy);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && bus.done !== 1'b0) early++;
      strobe(3'b001, 3'b010);
    end
    n_checks++;
    if (early !== 0) begin
      n_fail++;
      $display("FAIL count_early_done: got %0d early pulses, expected 0", early);
    end
    wait_done(k);
    n_checks++;
    if (k !== EXP_DIV) begin
      n_fail++;
      $display("FAIL count_done_latency: got %0d cycles, expected %0d", k, EXP_DIV);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL count_busy_in_done: got %0d, expected 0", bus.busy);
    end
    step();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL count_done_width: got %0d, expected 0", bus.done);
    end
    for (int ch = 0; ch < 3; ch++) begin
      bus.rd_ch = 2'(ch);
      #1;
      n_checks++;
      if ({bus.rd_hit, bus.rd_miss, bus.rd_l2hit, bus.rd_cycles, bus.rd_sat} !==
          {e_hit[ch], e_miss[ch], e_l2[ch], e_cyc[ch], 1'b0}) begin
        n_fail++;
        $display("FAIL count_ch%0d: got hit=%0d miss=%0d l2=%0d cyc=%0d sat=%0d, expected hit=%0d miss=%0d l2=%0d cyc=%0d sat=0",
                 ch, bus.rd_hit, bus.rd_miss, bus.rd_l2hit, bus.rd_cycles, bus.rd_sat,
                 e_hit[ch], e_miss[ch], e_l2[ch], e_cyc[ch]);
      end
      n_checks++;
      if (bus.rd_amat !== e_amat[ch]) begin
        n_fail++;
        $display("FAIL amat_ch%0d: got %h, expected %h", ch, bus.rd_amat, e_amat[ch]);
      end
    end
    bus.rd_ch = 2'd3;
    #1;
    n_checks++;
    if ({bus.rd_hit, bus.rd_miss, bus.rd_l2hit, bus.rd_cycles, bus.rd_sat, bus.rd_amat} !== '0) begin
      n_fail++;
      $display("FAIL rd_ch_oob: got hit=%0d miss=%0d cyc=%0d, expected all 0",
               bus.rd_hit, bus.rd_miss, bus.rd_cycles);
    end
    bus.rd_ch = 2'd0;
  endtask

  task automatic test_zero_window();
    start_window(16'd0);
    n_checks++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_win_done: got done=%0d busy=%0d, expected done=1 busy=0", bus.done, bus.busy);
    end
    bus.rd_ch = 2'd2;
    #1;
    n_checks++;
    if ({bus.rd_hit, bus.rd_miss, bus.rd_cycles} !== '0) begin
      n_fail++;
      $display("FAIL zero_win_counts: got hit=%0d miss=%0d cyc=%0d, expected 0",
               bus.rd_hit, bus.rd_miss, bus.rd_cycles);
    end
    step();
    bus.rd_ch = 2'd0;
  endtask

  task automatic test_abort();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%0d done=%0d, expected 0 0", bus.busy, bus.done);
    end
    start_window(16'd10);
    strobe(3'b011, 3'b000);
    strobe(3'b011, 3'b000);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_done: got %0d, expected 1", bus.done);
    end
    bus.rd_ch = 2'd0;
    #1;
    n_checks++;
    if ({bus.rd_hit, bus.rd_miss} !== {32'd2, 32'd0}) begin
      n_fail++;
      $display("FAIL abort_ch0: got hit=%0d miss=%0d, expected hit=2 miss=0", bus.rd_hit, bus.rd_miss);
    end
    bus.rd_ch = 2'd2;
    #1;
    n_checks++;
    if ({bus.rd_hit, bus.rd_miss, bus.rd_cycles} !== {32'd0, 32'd2, 40'd212}) begin
      n_fail++;
      $display("FAIL abort_ch2: got hit=%0d miss=%0d cyc=%0d, expected hit=0 miss=2 cyc=212",
               bus.rd_hit, bus.rd_miss, bus.rd_cycles);
    end
    step();
    start_window(16'd10);
    strobe(3'b001, 3'b000);
    bus.acc_stb = 1'b1;
    bus.l1_hit  = 3'b001;
    bus.abort   = 1'b1;
    step();
    drive_idle();
    bus.rd_ch = 2'd0;
    #1;
    n_checks++;
    if ({bus.done, bus.rd_hit} !== {1'b1, 32'd2}) begin
      n_fail++;
      $display("FAIL abort_with_strobe: got done=%0d hit=%0d, expected done=1 hit=2", bus.done, bus.rd_hit);
    end
    step();
  endtask

  task automatic test_illegal_start();
    int k;
    start_window(16'd3);
    strobe(3'b001, 3'b000);
    bus.start      = 1'b1;
    bus.window_len = 16'd0;
    step();
    bus.start      = 1'b0;
    n_checks++;
    if ({bus.busy, bus.done, bus.rd_hit} !== {1'b1, 1'b0, 32'd1}) begin
      n_fail++;
      $display("FAIL start_mid_count: got busy=%0d done=%0d hit=%0d, expected busy=1 done=0 hit=1",
               bus.busy, bus.done, bus.rd_hit);
    end
    strobe(3'b001, 3'b000);
    strobe(3'b001, 3'b000);
    wait_done(k);
    n_checks++;
    if ({k, bus.rd_hit} !== {EXP_DIV, 32'd3}) begin
      n_fail++;
      $display("FAIL start_mid_count_end: got latency=%0d hit=%0d, expected latency=%0d hit=3",
               k, bus.rd_hit, EXP_DIV);
    end
    step();
    strobe(3'b001, 3'b000);
    n_checks++;
    if ({bus.busy, bus.rd_hit} !== {1'b0, 32'd3}) begin
      n_fail++;
      $display("FAIL strobe_in_idle: got busy=%0d hit=%0d, expected busy=0 hit=3", bus.busy, bus.rd_hit);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    seen = 0;
    start_window(16'd10);
    repeat (3) strobe(3'b001, 3'b000);
    rst_n = 1'b0;
    #1;
    bus.rd_ch = 2'd0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.rd_hit, bus.rd_cycles} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%0d done=%0d hit=%0d cyc=%0d, expected all 0",
               bus.busy, bus.done, bus.rd_hit, bus.rd_cycles);
    end
    step();
    step();
    rst_n = 1'b1;
    repeat (5) begin
      step();
      if (bus.done) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got %0d done pulses, expected 0", seen);
    end
  endtask

  task automatic test_saturation();
    sbus.window_len = 16'd30;
    sbus.start      = 1'b1;
    step();
    sbus.start      = 1'b0;
    sbus.acc_stb    = 1'b1;
    sbus.l1_hit     = 3'b001;
    repeat (20) step();
    sbus.acc_stb    = 1'b0;
    sbus.l1_hit     = '0;
    sbus.rd_ch      = 2'd0;
    #1;
    n_checks++;
    if ({sbus.rd_hit, sbus.rd_sat, sbus.rd_cycles} !== {4'd15, 1'b1, 12'd20}) begin
      n_fail++;
      $display("FAIL sat_ch0: got hit=%0d sat=%0d cyc=%0d, expected hit=15 sat=1 cyc=20",
               sbus.rd_hit, sbus.rd_sat, sbus.rd_cycles);
    end
    sbus.rd_ch = 2'd1;
    #1;
    n_checks++;
    if ({sbus.rd_miss, sbus.rd_sat} !== {4'd15, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_ch1: got miss=%0d sat=%0d, expected miss=15 sat=1", sbus.rd_miss, sbus.rd_sat);
    end
    sbus.abort = 1'b1;
    step();
    sbus.abort = 1'b0;
    step();
    sbus.window_len = 16'd5;
    sbus.start      = 1'b1;
    step();
    sbus.start      = 1'b0;
    sbus.rd_ch      = 2'd0;
    #1;
    n_checks++;
    if ({sbus.rd_sat, sbus.rd_hit, sbus.busy} !== {1'b0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_clear_on_start: got sat=%0d hit=%0d busy=%0d, expected sat=0 hit=0 busy=1",
               sbus.rd_sat, sbus.rd_hit, sbus.busy);
    end
    sbus.abort = 1'b1;
    step();
    sbus.abort = 1'b0;
    step();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_count();
    test_zero_window();
    test_abort();
    test_illegal_start();
    test_mid_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_perf_monitor.md
Name: cache_perf_monitor

Overview:
- Synthesizable hardware performance monitor for N parallel cache systems that see a common access stream.
- Per channel, counts L1 hits, L1 misses, L2 hits and accumulated access latency over a programmable window of accesses.
- Optionally computes fixed-point AMAT per channel in hardware.
- Sits beside the cache_system_* instances and replaces software-side hit/miss tallying in benches and on-chip debug.

Parameters:
- NUM_CH, 3, number of monitored cache channels
- CNT_W, 32, width of hit/miss counters (saturating)
- WIN_W, 16, width of window_len
- L1_LAT, 1, cycles charged for an L1 hit
- L2_LAT, 5, extra cycles charged for an L1 miss
- MEM_LAT, 100, extra cycles charged for an L1+L2 miss

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a window; clears all counters
- abort  in  1  end window early; counters retained
- window_len  in  WIN_W  number of accesses per window, sampled on start
- acc_stb  in  1  one access presented to all channels this cycle
- l1_hit  in  NUM_CH  per-channel L1 hit, valid with acc_stb
- l2_hit  in  NUM_CH  per-channel L2 hit, valid with acc_stb
- busy  out  1  window in progress (COUNT or DIVIDE)
- done  out  1  one-cycle pulse at window completion
- rd_ch  in  clog2(NUM_CH)  result channel select
- rd_hit  out  CNT_W  L1 hits of rd_ch
- rd_miss  out  CNT_W  L1 misses of rd_ch
- rd_l2hit  out  CNT_W  L2 hits (among L1 misses) of rd_ch
- rd_cycles  out  CNT_W+8  accumulated latency of rd_ch
- rd_sat  out  1  some counter of rd_ch saturated
- rd_amat  out  16  AMAT of rd_ch, unsigned Q8.8

Behaviour:
- Reset: state IDLE; all counters, busy, done, rd_* = 0.
- FSM states: IDLE, COUNT, DIVIDE, DONE.
- IDLE + start:
  - Clear all counters and latch window_len.
  - If window_len==0, go to DONE; else go to COUNT.
  - start is ignored in every state other than IDLE.
- COUNT, per acc_stb cycle, per channel c:
  - l1_hit[c]: hit++, cycles += L1_LAT.
  - Else if l2_hit[c]: miss++, l2hit++, cycles += L1_LAT+L2_LAT.
  - Else: miss++, cycles += L1_LAT+L2_LAT+MEM_LAT.
  - l2_hit is ignored when l1_hit is set.
- Window end:
  - The internal access counter increments per strobe.
  - On the edge accepting the window_len-th strobe, go to DIVIDE (feature on) or DONE.
- abort in COUNT: go to DONE on the next edge; the strobe in that same cycle is still counted.
- abort in IDLE, DIVIDE or DONE: ignored.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE.
- Counters saturate at all-ones and never wrap. Any saturation sets that channel's sticky sat flag, cleared by start or reset.
- Results:
  - rd_* are combinational from rd_ch and hold until the next start.
  - rd_ch >= NUM_CH returns 0 on every rd_* output.
  - Results are readable during COUNT (live values).
- acc_stb outside COUNT: ignored.
- rst_n asserted mid-window: immediate return to reset state; no done pulse.

Optional Feature:
- Macro: CACHE_PERF_AMAT_EN
- Defined:
  - DIVIDE runs a sequential restoring divide per channel, in order 0..NUM_CH-1.
  - Computes (cycles<<8)/(hit+miss), taking CNT_W+24 iterations plus 1 load cycle per channel.
  - Result stored as 16-bit Q8.8; any quotient above 0xFFFF saturates to 0xFFFF.
  - A zero denominator gives 0.
  - done pulses one cycle after the final channel completes.
- Not defined:
  - DIVIDE is never entered.
  - rd_amat is tied to 0.
  - done pulses in the cycle after the final strobe.

Decomposition:
- Package cache_perf_pkg:
  - state enum (IDLE/COUNT/DIVIDE/DONE);
  - latency-class encoding (L1HIT/L2HIT/MEMACC);
  - Q8.8 fraction width constant (8).
- Sub-module perf_div_seq:
  - parametrised unsigned sequential divider with start/busy/done handshake;
  - instantiated only under CACHE_PERF_AMAT_EN.

Test Plan:
- Reset: rst_n=0 with random inputs -> busy=0, done=0, all rd_* = 0 for every rd_ch.
- Count and cycle accounting: window_len=4, 4 strobes with ch0 L1 hit, ch1 L1 miss/L2 hit, ch2 both miss:
  - ch0: hit=4, cycles=4.
  - ch1: miss=4, l2hit=4, cycles=24.
  - ch2: miss=4, l2hit=0, cycles=424.
  - done pulses once (cycle after 4th strobe when feature off).
- AMAT (feature on), same stimulus:
  - rd_amat = 0x0100 / 0x0600 / 0x6A00 for ch0/1/2.
  - done exactly 3*(CNT_W+25) cycles after the last strobe.
- Zero window and early end:
  - window_len=0 -> done pulses the cycle after start, all counts 0.
  - abort after 2 of 10 strobes -> hit+miss = 2 (or 3 if a strobe coincides with abort).
- Saturation (CNT_W=4): 20 ch0 hits -> rd_hit=15, rd_sat=1; the next start clears rd_sat to 0.
- Illegal start and mid-window reset:
  - start pulsed mid-COUNT -> ignored, counts continue.
  - rst_n=0 mid-window -> all outputs 0, no done pulse.
  - rd_ch=3 -> all rd_* = 0.
